// File: rtl/hdmi_info_frame_pkg.sv
// Shared InfoFrame definitions: type codes, payload limit, FSM states and bank storage types.
package hdmi_info_frame_pkg;

    localparam logic [7:0] INFO_TYPE_VENDOR = 8'h81;
    localparam logic [7:0] INFO_TYPE_AVI    = 8'h82;
    localparam logic [7:0] INFO_TYPE_SPD    = 8'h83;
    localparam logic [7:0] INFO_TYPE_AUDIO  = 8'h84;

    localparam int MAX_PAYLOAD = 27;

    typedef enum logic [1:0] {IDLE, SUM, PEND} info_state_t;

    typedef logic [7:0] shadow_bank_t [1:MAX_PAYLOAD];
    typedef logic [7:0] active_bank_t [0:MAX_PAYLOAD];

endpackage

// File: rtl/info_frame_checksum.sv
// Serial 8-bit byte accumulator producing a two's-complement checksum, so that
// seed + all added bytes + csum == 0 mod 256.
module info_frame_checksum (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       add,
    input  logic       finish,
    input  logic [7:0] add_val,
    output logic [7:0] csum
);

    logic [7:0] acc;
    logic [7:0] acc_next;

    function automatic logic [7:0] negate8(input logic [7:0] v);
        return (~v) + 8'd1;
    endfunction

    assign acc_next = acc + add_val;

    // finish folds the final byte in and latches the negated total in the same edge
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= 8'h00;
            csum <= 8'h00;
        end else if (load) begin
            acc <= load_val;
        end else if (add) begin
            acc <= acc_next;
            if (finish) begin
                csum <= negate8(acc_next);
            end
        end
    end

endmodule

// File: rtl/info_frame_buffer.sv
// Double-buffered InfoFrame source: shadow bank written by software, checksummed
// serially on commit, then published to the active bank when the scheduler allows.
module info_frame_buffer
    import hdmi_info_frame_pkg::*;
#(
    parameter logic [7:0] INFO_TYPE = INFO_TYPE_SPD,
    parameter logic [7:0] VERSION   = 8'd1,
    parameter logic [4:0] LENGTH    = 5'd25
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    input  logic             swap_ok,
    output logic             busy,
    output logic             valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    if (LENGTH < 5'd1 || LENGTH > 5'd27) begin : g_bad_length
        $error("info_frame_buffer: LENGTH must be in 1..27");
    end

    localparam logic [7:0] HDR_SUM = INFO_TYPE + VERSION + {3'b000, LENGTH};

    info_state_t  state;
    logic [4:0]   idx;
    shadow_bank_t shadow;
    active_bank_t active;
    logic         wr_accept;
    logic         sum_load;
    logic         sum_add;
    logic         sum_finish;
    logic [7:0]   csum;

    assign header     = {3'b000, LENGTH, VERSION, INFO_TYPE};
    assign wr_accept  = (state == IDLE) && wr_en && (wr_addr != 5'd0) && (wr_addr <= 5'd27);
    assign sum_load   = (state == IDLE) && commit;
    assign sum_add    = (state == SUM);
    assign sum_finish = sum_add && (idx == LENGTH);

    info_frame_checksum u_checksum (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .load      (sum_load),
        .load_val  (HDR_SUM),
        .add       (sum_add),
        .finish    (sum_finish),
        .add_val   (shadow[idx]),
        .csum      (csum)
    );

    // A write coinciding with commit lands before SUM reads shadow, so it is summed
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= 5'd1;
            busy  <= 1'b0;
            valid <= 1'b0;
            for (int i = 1; i <= MAX_PAYLOAD; i++) shadow[i] <= 8'h00;
            for (int i = 0; i <= MAX_PAYLOAD; i++) active[i] <= 8'h00;
        end else begin
            if (wr_accept) begin
                shadow[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (commit) begin
                        state <= SUM;
                        idx   <= 5'd1;
                        busy  <= 1'b1;
                    end
                end
                SUM: begin
                    if (idx == LENGTH) begin
                        idx   <= 5'd1;
                        state <= PEND;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                PEND: begin
                    if (swap_ok) begin
                        for (int i = 1; i <= MAX_PAYLOAD; i++) begin
                            active[i] <= (i <= int'(LENGTH)) ? shadow[i] : 8'h00;
                        end
                        active[0] <= csum;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sub[i] carries PB(7i)..PB(7i+6), lowest-numbered byte in the LSBs
    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sub[i][8*j +: 8] = active[7*i + j];
            end
        end
    end

endmodule

// File: tb/tb_info_frame_buffer.sv
// Directed bench for info_frame_buffer: expected frames queued at commit, compared at swap.
`timescale 1ns/1ps
module tb_info_frame_buffer;

    typedef logic [3:0][55:0] frame_t;

    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    logic        reset_n;
    logic        wr_en, commit, swap_ok;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy, valid;
    logic [23:0] header;
    frame_t      sub;

    logic        wr_en_b, commit_b, swap_ok_b;
    logic [4:0]  wr_addr_b;
    logic [7:0]  wr_data_b;
    logic        busy_b, valid_b;
    logic [23:0] header_b;
    frame_t      sub_b;

    info_frame_buffer dut (
        .clk_pixel (clk_pixel), .reset_n (reset_n),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .commit (commit), .swap_ok (swap_ok),
        .busy (busy), .valid (valid), .header (header), .sub (sub)
    );

    info_frame_buffer #(.LENGTH(5'd10)) dut_b (
        .clk_pixel (clk_pixel), .reset_n (reset_n),
        .wr_en (wr_en_b), .wr_addr (wr_addr_b), .wr_data (wr_data_b),
        .commit (commit_b), .swap_ok (swap_ok_b),
        .busy (busy_b), .valid (valid_b), .header (header_b), .sub (sub_b)
    );

    int checks = 0;
    int errors = 0;
    frame_t exp_q[$];
    frame_t exp_q_b[$];
    logic [27:1][7:0] model;
    logic [27:1][7:0] model_b;
    frame_t prev;
    int busy_seen;

    task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t model_frame(input logic [27:1][7:0] sh, input int len);
        logic [7:0] s;
        frame_t f;
        s = 8'h83 + 8'h01 + 8'(len);
        f = '0;
        for (int i = 1; i <= 27; i++) begin
            if (i <= len) begin
                s = s + sh[i];
                f[i/7][8*(i%7) +: 8] = sh[i];
            end
        end
        f[0][7:0] = 8'h00 - s;
        return f;
    endfunction

    function automatic logic [7:0] frame_sum(input frame_t f, input logic [23:0] h);
        logic [7:0] s;
        s = h[7:0] + h[15:8] + h[23:16];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 7; j++)
                s = s + f[i][8*j +: 8];
        return s;
    endfunction

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [4:0] a, input logic [7:0] d);
        if (sel) begin wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d; end
        else     begin wr_en   = 1'b1; wr_addr   = a; wr_data   = d; end
        step();
        wr_en = 1'b0;
        wr_en_b = 1'b0;
    endtask

    task automatic pulse_commit(input bit sel);
        if (sel) commit_b = 1'b1; else commit = 1'b1;
        step();
        commit = 1'b0;
        commit_b = 1'b0;
    endtask

    // Waits (bounded) for busy to fall, then checks latency and the published frame
    task automatic wait_swap(input bit sel, input string tag, input int exp_lat, input int already);
        int n;
        frame_t f;
        frame_t obs;
        logic [23:0] h;
        logic b;
        n = already;
        b = sel ? busy_b : busy;
        while (b === 1'b1 && n < 300) begin
            step();
            n++;
            b = sel ? busy_b : busy;
        end
        check({tag, "_done"}, b, 1'b0);
        if (b !== 1'b0) return;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_qnonempty"}, (sel ? exp_q_b.size() : exp_q.size()) > 0, 1'b1);
        if ((sel ? exp_q_b.size() : exp_q.size()) == 0) return;
        f   = sel ? exp_q_b.pop_front() : exp_q.pop_front();
        obs = sel ? sub_b : sub;
        h   = sel ? header_b : header;
        check({tag, "_frame"}, obs, f);
        check({tag, "_valid"}, sel ? valid_b : valid, 1'b1);
        check({tag, "_sum0"}, frame_sum(obs, h), 8'h00);
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; swap_ok = 1'b1;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; commit_b = 1'b0; swap_ok_b = 1'b1;
        model = '0;
        model_b = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_sub", sub, '0);
        check("header", header, 24'h190183);
        check("header_b", header_b, 24'h0A0183);
        @(posedge clk_pixel); #1;
        reset_n = 1'b1;
        step();

        // Empty payload
        exp_q.push_back(model_frame(model, 25));
        pulse_commit(0);
        check("t1_busy", busy, 1'b1);
        check("t1_valid_pre", valid, 1'b0);
        wait_swap(0, "t1", 26, 0);
        check("t1_pb0", sub[0][7:0], 8'h63);

        // PB1 and PB25
        wr(0, 5'd1, 8'h01);  model[1] = 8'h01;
        wr(0, 5'd25, 8'hFF); model[25] = 8'hFF;
        exp_q.push_back(model_frame(model, 25));
        pulse_commit(0);
        wait_swap(0, "t2", 26, 0);
        check("t2_pb25", sub[3][39:32], 8'hFF);
        check("t2_pb0", sub[0][7:0], 8'h63);

        // Scheduler holds off the swap; writes while busy are dropped
        swap_ok = 1'b0;
        wr(0, 5'd3, 8'h22); model[3] = 8'h22;
        prev = sub;
        exp_q.push_back(model_frame(model, 25));
        pulse_commit(0);
        wr(0, 5'd2, 8'hAA);
        repeat (38) step();
        check("t3_busy_hold", busy, 1'b1);
        check("t3_sub_hold", sub, prev);
        check("t3_valid_hold", valid, 1'b1);
        swap_ok = 1'b1;
        wait_swap(0, "t3", 1, 0);
        check("t3_pb2_old", sub[0][23:16], 8'h00);
        check("t3_pb3", sub[0][31:24], 8'h22);

        // Second commit during SUM is ignored
        exp_q.push_back(model_frame(model, 25));
        pulse_commit(0);
        repeat (4) step();
        pulse_commit(0);
        wait_swap(0, "t4", 26, 5);
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy !== 1'b0) busy_seen++;
        end
        check("t4_single_swap", busy_seen, 0);

        // Reset in the middle of SUM
        pulse_commit(0);
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_valid", valid, 1'b0);
        check("t5_rst_sub", sub, '0);
        model = '0;
        @(posedge clk_pixel); #1;
        reset_n = 1'b1;
        step();
        exp_q.push_back(model_frame(model, 25));
        pulse_commit(0);
        wait_swap(0, "t5", 26, 0);

        // Illegal addresses ignored; write with commit is summed
        wr(0, 5'd0, 8'h11);
        wr(0, 5'd30, 8'h22);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h40; model[7] = 8'h40;
        exp_q.push_back(model_frame(model, 25));
        pulse_commit(0);
        wait_swap(0, "t6", 26, 0);
        check("t6_pb7", sub[1][7:0], 8'h40);

        // LENGTH=10 instance: bytes past LENGTH are excluded and zeroed
        wr(1, 5'd11, 8'h55); model_b[11] = 8'h55;
        wr(1, 5'd5, 8'h10);  model_b[5] = 8'h10;
        exp_q_b.push_back(model_frame(model_b, 10));
        pulse_commit(1);
        wait_swap(1, "t7", 11, 0);
        check("t7_pb11", sub_b[1][39:32], 8'h00);
        check("t7_pb5", sub_b[0][47:40], 8'h10);
        check("t7_pb0", sub_b[0][7:0], 8'h62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
